// File: rtl/axi_demo_reg_slave.sv
// AXI4-Lite slave terminating axiDemo address/data/strobe traffic in a small register file.
// Single-entry AW and W holding registers feed one write commit per response slot; reads return in one cycle.

package axi_demo_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] axi_addr_t;
    typedef logic [DATA_W-1:0] axi_data_t;
    typedef logic [STRB_W-1:0] axi_strobe_t;
    typedef logic [1:0]        axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
endpackage

module axi_demo_reg_slave
    import axi_demo_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic              aw_full_q, aw_full_d;
    axi_addr_t         aw_addr_q, aw_addr_d;
    logic              w_full_q, w_full_d;
    axi_data_t         w_data_q, w_data_d;
    axi_strobe_t       w_strb_q, w_strb_d;
    logic              b_valid_q, b_valid_d;
    axi_resp_t         b_resp_q, b_resp_d;
    logic              r_valid_q, r_valid_d;
    axi_data_t         r_data_q, r_data_d;
    axi_resp_t         r_resp_q, r_resp_d;
    axi_data_t         regs_q [NUM_REGS];
    axi_data_t         regs_d [NUM_REGS];

    axi_addr_t         wr_off, rd_off;
    logic              wr_hit, rd_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              aw_hs, w_hs, ar_hs, commit;

    assign aw_ready = !aw_full_q;
    assign w_ready  = !w_full_q;
    assign ar_ready = !r_valid_q || r_ready;

    assign b_valid = b_valid_q;
    assign b_resp  = b_resp_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_resp  = r_resp_q;

    // Address decode relative to BASE_ADDR; wrap-around offsets land out of range.
    always_comb begin
        wr_off = aw_addr_q - BASE_ADDR;
        rd_off = ar_addr - BASE_ADDR;
        wr_hit = (wr_off[1:0] == 2'b00) && (wr_off[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS));
        rd_hit = (rd_off[1:0] == 2'b00) && (rd_off[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS));
        wr_idx = wr_off[IDX_W+1:2];
        rd_idx = rd_off[IDX_W+1:2];
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        regs_d    = regs_q;

        aw_hs  = aw_valid && aw_ready;
        w_hs   = w_valid && w_ready;
        ar_hs  = ar_valid && ar_ready;
        commit = aw_full_q && w_full_q && (!b_valid_q || b_ready);

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = aw_addr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = w_data;
            w_strb_d = w_strb;
        end

        if (b_valid_q && b_ready) begin
            b_valid_d = 1'b0;
        end
        // A commit refills the response slot in the same cycle it drains.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        if (r_valid_q && r_ready) begin
            r_valid_d = 1'b0;
        end
        // Reads sample regs_q, so a same-cycle commit is not visible yet.
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_hit ? regs_q[rd_idx] : '0;
            r_resp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi_demo_reg_slave.sv
// Bench for axi_demo_reg_slave: vector table, directed multi-cycle sequences, and random traffic
// checked against a byte-array model of the register file.

module tb_axi_demo_reg_slave;

    localparam int unsigned NREGS = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk, rst;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] aw_addr, w_data, ar_addr, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    int n_checks = 0;
    int n_fail   = 0;

    axi_demo_reg_slave #(.NUM_REGS(NREGS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register file model as a flat byte array addressed by byte offset.
    logic [7:0] mdl [NREGS*4];

    function automatic bit mdl_hit(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off % 4 == 0) && (off / 4 < NREGS);
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int unsigned off;
        off = addr - BASE;
        resp = mdl_hit(addr) ? 2'b00 : 2'b10;
        if (mdl_hit(addr))
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[off + b] = data[8*b +: 8];
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        int unsigned off;
        off = addr - BASE;
        if (!mdl_hit(addr)) return 32'h0;
        return {mdl[off+3], mdl[off+2], mdl[off+1], mdl[off]};
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < NREGS*4; i++) mdl[i] = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake wait expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done;
        logic aw_rdy, w_rdy;
        int t;
        aw_done = 0; w_done = 0; t = 0; resp = 2'b11;
        aw_addr = addr; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        while (!(aw_done && w_done) && t < 20) begin
            aw_rdy = aw_ready; w_rdy = w_ready;
            tick(); t++;
            if (aw_valid && aw_rdy) begin aw_done = 1; aw_valid = 1'b0; end
            if (w_valid && w_rdy) begin w_done = 1; w_valid = 1'b0; end
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        if (!(aw_done && w_done)) timeout("write_accept");
        t = 0;
        while (!b_valid && t < 20) begin tick(); t++; end
        if (!b_valid) timeout("write_resp");
        else begin resp = b_resp; tick(); end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic rdy;
        int t;
        t = 0; data = 32'hxxxx_xxxx; resp = 2'b11;
        ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
        rdy = 1'b0;
        while (!rdy && t < 20) begin
            rdy = ar_ready;
            tick(); t++;
        end
        ar_valid = 1'b0;
        if (!rdy) timeout("read_accept");
        else if (!r_valid) timeout("read_latency");
        else begin data = r_data; resp = r_resp; tick(); end
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [1:0]  resp, mresp;
        logic [31:0] rd, addr, data;
        logic [3:0]  strb;

        rst = 1'b1;
        aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 1; r_ready = 1;
        aw_addr = 0; w_data = 0; w_strb = 0; ar_addr = 0;
        mdl_clear();

        vecs[0] = '{32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h08, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h04, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h04, 32'hFFFF_FFFF, 2'b00};
        vecs[2] = '{32'h04, 32'hAABB_CCDD, 4'h0, 2'b00, 32'h04, 32'hFFFF_FFFF, 2'b00};
        vecs[3] = '{32'h04, 32'h0000_0000, 4'hA, 2'b00, 32'h04, 32'h00FF_00FF, 2'b00};
        vecs[4] = '{32'h42, 32'h1234_5678, 4'hF, 2'b10, 32'h40, 32'h0000_0000, 2'b10};
        vecs[5] = '{32'h40, 32'h1234_5678, 4'hF, 2'b10, 32'h3C, 32'h0000_0000, 2'b00};
        vecs[6] = '{32'h3C, 32'hCAFE_F00D, 4'hC, 2'b00, 32'h3C, 32'hCAFE_0000, 2'b00};
        vecs[7] = '{32'hFFFF_FFFC, 32'h1, 4'hF, 2'b10, 32'h08, 32'hDEAD_BEEF, 2'b00};
        vecs[8] = '{32'h00, 32'h1357_9BDF, 4'h3, 2'b00, 32'h00, 32'h0000_9BDF, 2'b00};

        repeat (3) tick();
        check("rst_aw_ready", aw_ready, 1);
        check("rst_w_ready", w_ready, 1);
        check("rst_ar_ready", ar_ready, 1);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_resp", b_resp, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_resp", r_resp, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, resp);
            mdl_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, mresp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
            do_read(vecs[i].raddr, rd, resp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rresp", i), resp, vecs[i].rresp);
        end

        // Write latency: AW+W accepted together, response two cycles later.
        aw_addr = 32'h10; w_data = 32'h0102_0304; w_strb = 4'hF;
        aw_valid = 1; w_valid = 1; b_ready = 1;
        tick();
        aw_valid = 0; w_valid = 0;
        check("lat_b_valid_early", b_valid, 0);
        check("lat_aw_ready_full", aw_ready, 0);
        tick();
        check("lat_b_valid", b_valid, 1);
        check("lat_b_resp", b_resp, 0);
        mdl_write(32'h10, 32'h0102_0304, 4'hF, mresp);
        tick();
        check("lat_b_drained", b_valid, 0);
        ar_addr = 32'h10; ar_valid = 1;
        tick();
        ar_valid = 0;
        check("lat_r_valid", r_valid, 1);
        check("lat_r_data", r_data, 32'h0102_0304);
        tick();
        check("lat_r_drained", r_valid, 0);

        // W arrives three cycles ahead of its AW.
        do_write(32'h04, 32'hFFFF_FFFF, 4'hF, resp);
        mdl_write(32'h04, 32'hFFFF_FFFF, 4'hF, mresp);
        w_data = 32'h1122_3344; w_strb = 4'h5; w_valid = 1;
        tick();
        w_valid = 0;
        check("early_w_ready", w_ready, 0);
        tick(); tick();
        check("early_w_ready_held", w_ready, 0);
        check("early_no_b", b_valid, 0);
        aw_addr = 32'h04; aw_valid = 1;
        tick();
        aw_valid = 0;
        tick();
        check("early_b_valid", b_valid, 1);
        check("early_b_resp", b_resp, 0);
        tick();
        mdl_write(32'h04, 32'h1122_3344, 4'h5, mresp);
        do_read(32'h04, rd, resp);
        check("early_rdata", rd, 32'hFF22_FF44);

        // Response backpressure with a second write queued behind it.
        b_ready = 0;
        aw_addr = 32'h42; w_data = 32'h9999_9999; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
        tick();
        aw_addr = 32'h14; w_data = 32'h55AA_55AA;
        tick();
        check("bp_first_b_valid", b_valid, 1);
        check("bp_first_b_resp", b_resp, 2'b10);
        tick();
        aw_valid = 0; w_valid = 0;
        for (int c = 0; c < 5; c++) begin
            check("bp_aw_ready", aw_ready, 0);
            check("bp_w_ready", w_ready, 0);
            check("bp_b_valid", b_valid, 1);
            check("bp_b_resp", b_resp, 2'b10);
            tick();
        end
        b_ready = 1;
        tick();
        check("bp_second_b_valid", b_valid, 1);
        check("bp_second_b_resp", b_resp, 2'b00);
        check("bp_aw_ready_free", aw_ready, 1);
        mdl_write(32'h14, 32'h55AA_55AA, 4'hF, mresp);
        tick();
        check("bp_b_drained", b_valid, 0);
        do_read(32'h14, rd, resp);
        check("bp_rdata", rd, mdl_read(32'h14));

        // Back-to-back reads, then r_ready dropped mid-burst.
        r_ready = 1; ar_valid = 1; ar_addr = 32'h0;
        tick();
        ar_addr = 32'h4;
        check("b2b_r0", r_data, mdl_read(32'h0));
        check("b2b_v0", r_valid, 1);
        tick();
        ar_addr = 32'h8;
        check("b2b_r1", r_data, mdl_read(32'h4));
        tick();
        check("b2b_r2", r_data, mdl_read(32'h8));
        ar_addr = 32'hC; r_ready = 0;
        #1;
        check("b2b_ar_ready_low", ar_ready, 0);
        tick();
        check("b2b_r_stable", r_data, mdl_read(32'h8));
        check("b2b_v_stable", r_valid, 1);
        r_ready = 1;
        tick();
        ar_valid = 0;
        check("b2b_r3", r_data, mdl_read(32'hC));
        tick();
        check("b2b_drained", r_valid, 0);

        // Asynchronous reset with AW held and a read response pending.
        do_write(32'h08, 32'hA5A5_A5A5, 4'hF, resp);
        r_ready = 0; ar_valid = 1; ar_addr = 32'h8; aw_valid = 1; aw_addr = 32'h8;
        tick();
        ar_valid = 0; aw_valid = 0;
        check("mid_r_pending", r_valid, 1);
        check("mid_aw_held", aw_ready, 0);
        #2 rst = 1;
        #1;
        check("mid_rst_aw_ready", aw_ready, 1);
        check("mid_rst_w_ready", w_ready, 1);
        check("mid_rst_r_valid", r_valid, 0);
        check("mid_rst_r_data", r_data, 0);
        check("mid_rst_b_valid", b_valid, 0);
        tick();
        rst = 0; r_ready = 1;
        mdl_clear();
        tick();
        do_read(32'h08, rd, resp);
        check("mid_rst_readback", rd, 0);
        check("mid_rst_readresp", resp, 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       addr = 32'(4 * $urandom_range(0, NREGS - 1));
            else if (sel == 8) addr = $urandom;
            else               addr = 32'(4 * $urandom_range(0, NREGS - 1) + $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, resp);
                mdl_write(addr, data, strb, mresp);
                check($sformatf("rnd_bresp@%08h", addr), resp, mresp);
            end else begin
                do_read(addr, rd, resp);
                check($sformatf("rnd_rdata@%08h", addr), rd, mdl_read(addr));
                check($sformatf("rnd_rresp@%08h", addr), resp, mdl_hit(addr) ? 2'b00 : 2'b10);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
